mem_link_master: RTL and testbench
==================================

MEM_LINK_MASTER -- requirements
Module: mem_link_master

Interface
REQ-001 Parameter TIMEOUT, default 24'hFFFFFF, is the maximum number of cycles to wait for a read response; 0 disables the timeout.
REQ-002 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  CPU memory request present.
REQ-005 req_ready  out  1  block idle; a request is accepted when req_valid && req_ready.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  write data, little-endian.
REQ-009 req_mask  in  4  byte enables; bit n enables req_wdata[8n+7:8n].
REQ-010 resp_valid  out  1  one-cycle pulse on read completion.
REQ-011 resp_rdata  out  32  read data; valid while resp_valid.
REQ-012 resp_err  out  1  qualifies resp_valid: timeout or malformed response.
REQ-013 stray_err  out  1  one-cycle pulse when an unsolicited message is discarded.
REQ-014 send_flag  out  1  one-cycle push into the channel transmitter.
REQ-015 send_length  out  5  message byte count.
REQ-016 send_data  out  72  message payload.
REQ-017 sendable  in  1  channel transmitter can accept a message.
REQ-018 recv_flag  out  1  one-cycle pop of the head received message.
REQ-019 recv_length  in  5  head message byte count.
REQ-020 recv_data  in  72  head message payload; valid while recvable.
REQ-021 recvable  in  1  a received message is available.

Function
REQ-022 The read message SHALL be: length 5; data[31:0] = addr; data[32] = 0; data[71:33] = 0.
REQ-023 The write message SHALL be: length 9; data[31:0] = wdata; data[63:32] = addr; data[67:64] = mask; data[71:68] = 0.
REQ-024 The FSM states SHALL be IDLE, SEND, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-025 On accept, the block SHALL register the message and enter SEND, except a write with mask 4'b0000, which SHALL be dropped and leave the FSM in IDLE.
REQ-026 In SEND with sendable = 1, the block SHALL assert send_flag for exactly one cycle; the next state SHALL be WAIT for a read and IDLE for a write.
REQ-027 send_data and send_length SHALL be held stable from SEND entry through the send_flag cycle.
REQ-028 In WAIT with recvable = 1, the block SHALL pulse recv_flag once and latch recv_data[31:0]; length 4 SHALL give resp_err = 0, any other length SHALL give resp_err = 1 with rdata = 0.
REQ-029 RESP SHALL last one cycle, with resp_valid = 1, and return to IDLE; minimum read latency is accept + 3 cycles when sendable and recvable are already high.
REQ-030 The WAIT counter SHALL clear on WAIT entry; when it reaches TIMEOUT (TIMEOUT ≠ 0), the FSM SHALL go to RESP with resp_err = 1 and rdata = 0.
REQ-031 A response that arrives after a timeout SHALL be handled as stray.
REQ-032 When recvable = 1 in any state other than WAIT, the message SHALL be popped (recv_flag pulse) and stray_err pulsed; pops SHALL be at most one per 2 cycles, so recvable is re-sampled after the pop.
REQ-033 Writes are posted: a write completes when send_flag fires and produces no resp_valid.
REQ-034 Only one request SHALL be outstanding at any time; channel FIFO order guarantees read-after-write ordering.

Reset
REQ-035 While RST_N = 0, the block SHALL immediately force IDLE, counter 0, and all outputs 0 except req_ready = 1; a mid-operation transaction SHALL be abandoned without send_flag or resp_valid.

Structure
REQ-036 A shared package SHALL hold: FSM state encoding, MSG_LEN_READ = 5, MSG_LEN_WRITE = 9, MSG_LEN_RESP = 4, and the field offsets 32 (flag/addr), 64 (mask).
REQ-037 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-038 Read 0x00000010, sendable = 1, response length 4 with data 0xDEADBEEF after 5 cycles -> one send (len 5, data[32] = 0); resp_valid with rdata 0xDEADBEEF, resp_err = 0.
REQ-039 Write addr 0x100, wdata 0x11223344, mask 4'b0101 -> send len 9, data[67:64] = 4'b0101, data[63:32] = 0x100; no resp_valid; req_ready returns 1 the cycle after send_flag.
REQ-040 sendable held 0 for 20 cycles during a read -> no send_flag and send_data stable; send occurs the first cycle sendable = 1.
REQ-041 TIMEOUT = 8, no response -> resp_valid with resp_err = 1 and rdata = 0 after 8 WAIT cycles; a later response gives recv_flag plus stray_err.
REQ-042 Response length 9 -> resp_err = 1; write with mask 0 -> no send_flag; RST_N low during WAIT -> IDLE, no resp_valid.

Source files
------------

// File: rtl/mem_link_master_pkg.sv
// Shared definitions for the memory-link master: FSM encoding, message lengths,
// payload field offsets and the request-to-message packing helpers.
package mem_link_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [4:0] MSG_LEN_READ  = 5'd5;
    localparam logic [4:0] MSG_LEN_WRITE = 5'd9;
    localparam logic [4:0] MSG_LEN_RESP  = 5'd4;

    // Bit 32 is the read flag in a read message and the address base in a write message.
    localparam int OFS_FLAG = 32;
    localparam int OFS_ADDR = 32;
    localparam int OFS_MASK = 64;

    function automatic logic [71:0] read_msg(input logic [31:0] addr);
        logic [71:0] msg;
        msg           = '0;
        msg[31:0]     = addr;
        msg[OFS_FLAG] = 1'b0;
        return msg;
    endfunction

    function automatic logic [71:0] write_msg(input logic [31:0] addr,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  mask);
        logic [71:0] msg;
        msg                 = '0;
        msg[31:0]           = wdata;
        msg[OFS_ADDR +: 32] = addr;
        msg[OFS_MASK +: 4]  = mask;
        return msg;
    endfunction

endpackage

// File: rtl/mem_link_master.sv
// Memory request master over a message channel: packs CPU reads/writes into link
// messages, waits for read responses with an optional timeout and discards strays.
//
// state | meaning
// IDLE  | ready for a CPU request; stray messages are popped here
// SEND  | message registered, waiting for sendable to push it
// WAIT  | read sent, waiting for the response (timeout counter running)
// RESP  | one-cycle resp_valid pulse back to the CPU
module mem_link_master
    import mem_link_master_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stray_err,
    output logic        send_flag,
    output logic [4:0]  send_length,
    output logic [71:0] send_data,
    input  logic        sendable,
    output logic        recv_flag,
    input  logic [4:0]  recv_length,
    input  logic [71:0] recv_data,
    input  logic        recvable
);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] wait_cnt;
    logic [23:0] wait_cnt_nxt;
    logic        cur_we;
    logic        pop_block;
    logic        accept;
    logic        drop;
    logic        load_msg;
    logic        take_resp;
    logic        timed_out;
    logic        bad_len;
    logic        recv_unused;

    assign recv_unused = ^recv_data[71:32];

    assign req_ready  = (state == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign drop       = req_we && (req_mask == 4'b0000);
    assign load_msg   = accept && !drop;

    // pop_block resets high so nothing is popped while held in reset, and it
    // spaces pops two cycles apart so recvable is re-sampled after each pop.
    assign recv_flag  = recvable && !pop_block;
    assign stray_err  = recv_flag && (state != ST_WAIT);
    assign send_flag  = (state == ST_SEND) && sendable;
    assign resp_valid = (state == ST_RESP);

    assign take_resp  = (state == ST_WAIT) && recv_flag;
    assign timed_out  = (state == ST_WAIT) && !take_resp && (TIMEOUT != 24'd0) &&
                        (wait_cnt == TIMEOUT - 24'd1);
    assign bad_len    = (recv_length != MSG_LEN_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load_msg) state_nxt = ST_SEND;
            ST_SEND: if (sendable) state_nxt = cur_we ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (take_resp || timed_out) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // wait_cnt holds the number of WAIT cycles already spent; zero outside WAIT.
    always_comb begin
        wait_cnt_nxt = '0;
        if ((state == ST_WAIT) && (state_nxt == ST_WAIT)) begin
            wait_cnt_nxt = wait_cnt + 24'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            pop_block   <= 1'b1;
            cur_we      <= 1'b0;
            send_length <= '0;
            send_data   <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            pop_block <= recv_flag;
            if (load_msg) begin
                cur_we      <= req_we;
                send_length <= req_we ? MSG_LEN_WRITE : MSG_LEN_READ;
                send_data   <= req_we ? write_msg(req_addr, req_wdata, req_mask)
                                      : read_msg(req_addr);
            end
            if (take_resp) begin
                resp_err   <= bad_len;
                resp_rdata <= bad_len ? 32'd0 : recv_data[31:0];
            end else if (timed_out) begin
                resp_err   <= 1'b1;
                resp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_link_master.sv
// Bench for mem_link_master: table vectors, directed corner sequences and a randomized
// run checked against a transaction-level model of the message link.
module tb_mem_link_master;

    typedef struct {
        int          at;
        logic [4:0]  len;
        logic [71:0] data;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [4:0]  rsp_len;
        logic [31:0] rsp_data;
        int          rsp_delay;
        logic        exp_send;
        logic [76:0] exp_msg;
        logic        exp_resp;
        logic [32:0] exp_rsp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stray_err;
    logic        send_flag;
    logic [4:0]  send_length;
    logic [71:0] send_data;
    logic        sendable = 1'b0;
    logic        recv_flag;
    logic [4:0]  recv_length = '0;
    logic [71:0] recv_data = '0;
    logic        recvable = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int n_stray = 0;
    int n_pop = 0;
    int cyc_n = 0;

    logic        pop_seen = 1'b0;
    logic        sendable_fixed = 1'b1;
    logic        rand_send = 1'b0;
    logic        auto_en = 1'b0;
    logic        auto_rand = 1'b0;
    logic        cur_read = 1'b0;
    logic [4:0]  auto_len = 5'd4;
    logic [71:0] auto_data = '0;
    int          auto_delay = 0;

    rsp_t        chan_q[$];
    rsp_t        mon_r;
    logic [76:0] obs_send[$];
    logic [76:0] exp_send[$];
    logic [32:0] obs_resp[$];
    logic [32:0] exp_resp[$];
    vec_t        vecs[7];

    mem_link_master #(.TIMEOUT(24'd8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_mask    (req_mask),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .stray_err   (stray_err),
        .send_flag   (send_flag),
        .send_length (send_length),
        .send_data   (send_data),
        .sendable    (sendable),
        .recv_flag   (recv_flag),
        .recv_length (recv_length),
        .recv_data   (recv_data),
        .recvable    (recvable)
    );

    always #5 CLK = ~CLK;

    // Channel side: delivers queued messages once their arrival cycle is reached.
    always @(posedge CLK) begin
        #1;
        cyc_n = cyc_n + 1;
        if (pop_seen && chan_q.size() > 0) chan_q.delete(0);
        if (chan_q.size() > 0 && chan_q[0].at <= cyc_n) begin
            recvable    = 1'b1;
            recv_length = chan_q[0].len;
            recv_data   = chan_q[0].data;
        end else begin
            recvable    = 1'b0;
            recv_length = '0;
            recv_data   = '0;
        end
        sendable = rand_send ? 1'($urandom_range(0, 1)) : sendable_fixed;
    end

    // Observer plus auto-responder: every read that leaves gets a response scheduled.
    always @(negedge CLK) begin
        pop_seen = recv_flag;
        if (stray_err) n_stray = n_stray + 1;
        if (recv_flag) n_pop = n_pop + 1;
        if (send_flag) begin
            obs_send.push_back({send_length, send_data});
            if (auto_en && cur_read) begin
                if (auto_rand) begin
                    mon_r.at   = cyc_n + 1 + int'($urandom_range(0, 5));
                    mon_r.len  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd4;
                    mon_r.data = {8'($urandom), $urandom, $urandom};
                end else begin
                    mon_r.at   = cyc_n + 1 + auto_delay;
                    mon_r.len  = auto_len;
                    mon_r.data = auto_data;
                end
                chan_q.push_back(mon_r);
                exp_resp.push_back((mon_r.len == 5'd4) ? {1'b0, mon_r.data[31:0]} : {1'b1, 32'h0});
            end
        end
        if (resp_valid) obs_resp.push_back({resp_err, resp_rdata});
    end

    task automatic check_v(input string name, input logic [76:0] act, input logic [76:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_obs();
        obs_send.delete();
        obs_resp.delete();
        exp_resp.delete();
    endtask

    task automatic push_rsp(input int at, input logic [4:0] len, input logic [71:0] data);
        rsp_t r;
        r.at   = at;
        r.len  = len;
        r.data = data;
        chan_q.push_back(r);
    endtask

    // Waits (bounded) for req_ready, presents the request, returns just after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
        int k;
        k = 0;
        @(negedge CLK);
        while (!req_ready && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check_i("issue_ready", int'(req_ready), 1);
        cur_read  = !we;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        settle();
        while (!req_ready && k < 300) begin
            settle();
            k++;
        end
        check_i("wait_idle", int'(req_ready), 1);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input logic [4:0] rl,
                                input logic [31:0] rd, input int dly);
        vec_t v;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.mask      = mask;
        v.rsp_len   = rl;
        v.rsp_data  = rd;
        v.rsp_delay = dly;
        v.exp_send  = !(we && mask == 4'h0);
        v.exp_msg   = we ? {5'd9, 4'h0, mask, addr, wdata} : {5'd5, 40'h0, addr};
        v.exp_resp  = !we;
        v.exp_rsp   = (rl == 5'd4) ? {1'b0, rd} : {1'b1, 32'h0};
        return v;
    endfunction

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    endtask

    initial begin
        #500000;
        n_fail = n_fail + 1;
        $display("FAIL watchdog: got still running, expected finished");
        summary();
        $finish;
    end

    initial begin
        int          first;
        int          bad;
        int          s0;
        int          p0;
        logic        t_err;
        logic [31:0] t_rd;
        logic        r_we;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [3:0]  r_mask;

        vecs[0] = mk(1'b0, 32'h0000_0010, 32'h0,          4'hF,    5'd4, 32'hDEAD_BEEF, 5);
        vecs[1] = mk(1'b1, 32'h0000_0100, 32'h1122_3344,  4'b0101, 5'd4, 32'h0,         0);
        vecs[2] = mk(1'b0, 32'h0000_0020, 32'h0,          4'hF,    5'd9, 32'hCAFE_F00D, 1);
        vecs[3] = mk(1'b1, 32'h0000_0044, 32'hA5A5_A5A5,  4'b0000, 5'd4, 32'h0,         0);
        vecs[4] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF,    5'd4, 32'h8000_0001, 0);
        vecs[5] = mk(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  4'b1111, 5'd4, 32'h0,         0);
        vecs[6] = mk(1'b0, 32'h0000_0008, 32'h0,          4'hF,    5'd0, 32'h0000_1234, 3);

        // Reset: outputs quiet even with a message waiting, then it is discarded as stray.
        push_rsp(0, 5'd4, 72'h1234);
        repeat (3) @(negedge CLK);
        check_i("rst_ready", int'(req_ready), 1);
        check_i("rst_flags", int'({send_flag, resp_valid, recv_flag, stray_err, resp_err}), 0);
        check_v("rst_send_msg", {send_length, send_data}, 77'd0);
        check_v("rst_rdata", {45'h0, resp_rdata}, 77'd0);
        RST_N = 1'b1;
        repeat (5) settle();
        check_i("rst_stray_cnt", n_stray, 1);
        check_i("rst_pop_cnt", n_pop, 1);

        auto_en = 1'b1;
        foreach (vecs[i]) begin
            clear_obs();
            auto_len   = vecs[i].rsp_len;
            auto_data  = {40'hAB_CDEF_0123, vecs[i].rsp_data};
            auto_delay = vecs[i].rsp_delay;
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
            repeat (15) settle();
            check_i($sformatf("v%0d_nsend", i), obs_send.size(), vecs[i].exp_send ? 1 : 0);
            if (vecs[i].exp_send && obs_send.size() > 0)
                check_v($sformatf("v%0d_msg", i), obs_send[0], vecs[i].exp_msg);
            check_i($sformatf("v%0d_nresp", i), obs_resp.size(), vecs[i].exp_resp ? 1 : 0);
            if (vecs[i].exp_resp && obs_resp.size() > 0)
                check_v($sformatf("v%0d_resp", i), {44'h0, obs_resp[0]}, {44'h0, vecs[i].exp_rsp});
        end

        // Posted write: send_flag in the SEND cycle, ready again the cycle after.
        clear_obs();
        issue(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0101);
        @(negedge CLK);
        check_i("wr_send_cycle", int'({send_flag, req_ready}), 2);
        @(negedge CLK);
        check_i("wr_ready_after", int'(req_ready), 1);
        repeat (4) settle();
        check_i("wr_no_resp", obs_resp.size(), 0);

        // Minimum read latency: send, pop, resp on the three cycles after accept.
        clear_obs();
        auto_len   = 5'd4;
        auto_data  = 72'h77_0000_0000_1357_9BDF;
        auto_delay = 0;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        @(negedge CLK);
        check_i("lat_send", int'(send_flag), 1);
        @(negedge CLK);
        check_i("lat_pop", int'({recv_flag, stray_err}), 2);
        @(negedge CLK);
        check_i("lat_resp", int'({resp_valid, resp_err}), 2);
        check_v("lat_rdata", {45'h0, resp_rdata}, {45'h0, 32'h1357_9BDF});

        // Backpressure: 20 cycles without sendable keep the message parked and stable.
        wait_idle();
        @(negedge CLK);
        sendable_fixed = 1'b0;
        clear_obs();
        auto_delay = 2;
        auto_data  = 72'h0_0000_0000_2468_ACE0;
        issue(1'b0, 32'hA5A5_0000, 32'h0, 4'hF);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (send_flag || send_data !== {40'h0, 32'hA5A5_0000} || send_length !== 5'd5) bad++;
        end
        sendable_fixed = 1'b1;
        check_i("hold_stable", bad, 0);
        @(negedge CLK);
        check_i("hold_send", int'({sendable, send_flag}), 3);
        wait_idle();
        repeat (2) settle();
        check_i("hold_nsend", obs_send.size(), 1);

        // Timeout with TIMEOUT = 8, then the late response is a stray.
        auto_en = 1'b0;
        clear_obs();
        issue(1'b0, 32'h0000_0200, 32'h0, 4'hF);
        first = -1;
        t_err = 1'b0;
        t_rd  = 32'hFFFF_FFFF;
        for (int c = 1; c <= 12; c++) begin
            settle();
            if (resp_valid && first < 0) begin
                first = c;
                t_err = resp_err;
                t_rd  = resp_rdata;
            end
        end
        check_i("to_cycle", first, 10);
        check_i("to_err", int'(t_err), 1);
        check_v("to_rdata", {45'h0, t_rd}, 77'd0);
        s0 = n_stray;
        p0 = n_pop;
        push_rsp(0, 5'd4, 72'h55);
        repeat (4) settle();
        check_i("late_stray", n_stray - s0, 1);
        check_i("late_pop", n_pop - p0, 1);
        check_i("late_no_resp", obs_resp.size(), 1);

        // Reset while waiting for a response abandons the read.
        clear_obs();
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        repeat (3) settle();
        #2 RST_N = 1'b0;
        #1 check_i("rst_wait_ready", int'({req_ready, resp_valid, send_flag}), 4);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) settle();
        check_i("rst_wait_no_resp", obs_resp.size(), 0);
        check_i("rst_wait_idle", int'(req_ready), 1);
        check_i("rst_wait_nsend", obs_send.size(), 1);

        // Randomized traffic against the transaction-level model.
        clear_obs();
        exp_send.delete();
        s0 = n_stray;
        rand_send = 1'b1;
        auto_en   = 1'b1;
        auto_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_mask  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (!(r_we && r_mask == 4'h0))
                exp_send.push_back(r_we ? {5'd9, 4'h0, r_mask, r_addr, r_wdata}
                                        : {5'd5, 40'h0, r_addr});
            issue(r_we, r_addr, r_wdata, r_mask);
        end
        wait_idle();
        repeat (15) settle();
        rand_send = 1'b0;
        check_i("rnd_nsend", obs_send.size(), exp_send.size());
        for (int j = 0; j < exp_send.size() && j < obs_send.size(); j++)
            check_v($sformatf("rnd_msg%0d", j), obs_send[j], exp_send[j]);
        check_i("rnd_nresp", obs_resp.size(), exp_resp.size());
        for (int j = 0; j < exp_resp.size() && j < obs_resp.size(); j++)
            check_v($sformatf("rnd_resp%0d", j), {44'h0, obs_resp[j]}, {44'h0, exp_resp[j]});
        check_i("rnd_stray", n_stray - s0, 0);

        summary();
        $finish;
    end

endmodule
